// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode: a circular {instr, pc} FIFO with
// a valid/ready handshake on both sides and a single-cycle flush on redirect.
module fetch_buffer #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_instr,
  output logic [XLEN-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
  localparam logic [AW-1:0] PTR_ZERO   = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);

  logic [XLEN-1:0] instr_mem_r [DEPTH];
  logic [XLEN-1:0] pc_mem_r    [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            push_s;
  logic            pop_s;

  // Handshake flags and head presentation, all derived from registered state.
  always_comb begin
    in_ready  = (count_r != FULL_COUNT);
    out_valid = (count_r != CNT_ZERO);
    push_s    = in_valid & in_ready;
    pop_s     = out_valid & out_ready;
    count     = count_r;
    // An empty head reads as all-zero, which the decoder treats as a NOP.
    if (out_valid) begin
      out_instr = instr_mem_r[rd_ptr_r];
      out_pc    = pc_mem_r[rd_ptr_r];
    end else begin
      out_instr = {XLEN{1'b0}};
      out_pc    = {XLEN{1'b0}};
    end
  end

  // Pointer and occupancy update; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; intentionally not reset, a dropped push leaves it untouched.
  always_ff @(posedge clk) begin
    if (resetn && !flush && push_s) begin
      instr_mem_r[wr_ptr_r] <= in_instr;
      pc_mem_r[wr_ptr_r]    <= in_pc;
    end
  end

endmodule
